// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - control and status bundle between the instruction sequencer and the ALU datapath
interface instruction_sequencer_if;
  logic [15:0] IR_Value;
  logic [3:0]  Flags;
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [2:0]  RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [3:0]  RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel;
  logic [1:0]  ARF_OutDSel;
  logic [1:0]  ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH;
  logic        IR_Write;
  logic        Mem_WR;
  logic        Mem_CS;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic [1:0]  MuxCSel;
  logic        MuxDSel;
  logic        DR_E;
  logic [1:0]  DR_FunSel;

  modport master (
    input  IR_Value, Flags,
    output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
    output ALU_FunSel, ALU_WF,
    output ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
    output IR_LH, IR_Write, Mem_WR, Mem_CS,
    output MuxASel, MuxBSel, MuxCSel, MuxDSel, DR_E, DR_FunSel
  );

  modport slave (
    output IR_Value, Flags,
    input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
    input  ALU_FunSel, ALU_WF,
    input  ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
    input  IR_LH, IR_Write, Mem_WR, Mem_CS,
    input  MuxASel, MuxBSel, MuxCSel, MuxDSel, DR_E, DR_FunSel
  );
endinterface

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - hardwired sequencer: two-byte fetch, decode and execute micro-ops for the ALU datapath
// Optional SEQ_SINGLE_STEP_EN adds a Step input that gates the start of each fetch.
module instruction_sequencer #(
  parameter int SC_W = 3
) (
  input  logic                   Clock,
  input  logic                   Reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                   Step,
`endif
  instruction_sequencer_if.master dp,
  output logic [SC_W-1:0]        T_State,
  output logic                   Halted,
  output logic                   Illegal
);

  typedef enum logic {RUN, HALT} mode_t;

  mode_t           mode_q, mode_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic            last, hold;

  logic [3:0] opcode;
  logic       s_bit;
  logic [2:0] dst, src1, src2;
  logic [1:0] rsel;
  logic       unused_bits;

  assign opcode      = dp.IR_Value[15:12];
  assign s_bit       = dp.IR_Value[11];
  assign dst         = dp.IR_Value[10:8];
  assign src1        = dp.IR_Value[7:5];
  assign src2        = dp.IR_Value[4:2];
  assign rsel        = dp.IR_Value[9:8];
  assign unused_bits = ^{dp.IR_Value[1:0], dp.Flags[2:0]};

  function automatic logic [3:0] rf_onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

  function automatic logic [2:0] arf_onehot(input logic [1:0] idx);
    case (idx)
      2'b10:   return 3'b010;
      2'b11:   return 3'b001;
      default: return 3'b100;
    endcase
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      mode_q <= RUN;
      sc_q   <= '0;
    end else begin
      mode_q <= mode_d;
      sc_q   <= sc_d;
    end
  end

  always_comb begin
    dp.RF_OutASel  = 3'b000;
    dp.RF_OutBSel  = 3'b000;
    dp.RF_FunSel   = 3'b000;
    dp.RF_RegSel   = 4'b0000;
    dp.RF_ScrSel   = 4'b0000;
    dp.ALU_FunSel  = 5'b00000;
    dp.ALU_WF      = 1'b0;
    dp.ARF_OutCSel = 2'b00;
    dp.ARF_OutDSel = 2'b00;
    dp.ARF_FunSel  = 2'b00;
    dp.ARF_RegSel  = 3'b000;
    dp.IR_LH       = 1'b0;
    dp.IR_Write    = 1'b0;
    dp.Mem_WR      = 1'b0;
    dp.Mem_CS      = 1'b1;
    dp.MuxASel     = 2'b00;
    dp.MuxBSel     = 2'b00;
    dp.MuxCSel     = 2'b00;
    dp.MuxDSel     = 1'b0;
    dp.DR_E        = 1'b0;
    dp.DR_FunSel   = 2'b00;
    Illegal        = 1'b0;
    mode_d         = mode_q;
    sc_d           = sc_q;
    last           = 1'b0;
    hold           = 1'b0;

    if (Reset) begin
      dp.RF_FunSel  = 3'b011;
      dp.RF_RegSel  = 4'b1111;
      dp.RF_ScrSel  = 4'b1111;
      dp.ARF_FunSel = 2'b11;
      dp.ARF_RegSel = 3'b111;
    end else if (mode_q == HALT) begin
      sc_d = '0;
    end else begin
      if (sc_q == SC_W'(0) || sc_q == SC_W'(1)) begin
`ifdef SEQ_SINGLE_STEP_EN
        hold = (sc_q == SC_W'(0)) && !Step;
`endif
        if (!hold) begin
          dp.ARF_OutDSel = 2'b00;
          dp.Mem_CS      = 1'b0;
          dp.IR_Write    = 1'b1;
          dp.IR_LH       = (sc_q == SC_W'(1));
          dp.ARF_FunSel  = 2'b01;
          dp.ARF_RegSel  = 3'b100;
        end
      end else if (sc_q == SC_W'(2)) begin
        last = 1'b1;
        case (opcode)
          4'h0, 4'h1: begin
            // BNE only branches when the zero flag (bit 3) is clear
            if (opcode == 4'h0 || !dp.Flags[3]) begin
              dp.MuxBSel    = 2'b11;
              dp.ARF_FunSel = 2'b10;
              dp.ARF_RegSel = 3'b100;
            end
          end
          4'h2: begin
            dp.MuxASel   = 2'b11;
            dp.RF_FunSel = 3'b010;
            dp.RF_RegSel = rf_onehot(rsel);
          end
          4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
            if (opcode != 4'h8 && !src2[2]) begin
              Illegal = 1'b1;
            end else begin
              case (opcode)
                4'h3:    dp.ALU_FunSel = 5'b10100;
                4'h4:    dp.ALU_FunSel = 5'b10110;
                4'h5:    dp.ALU_FunSel = 5'b10111;
                4'h6:    dp.ALU_FunSel = 5'b11000;
                4'h7:    dp.ALU_FunSel = 5'b11001;
                default: dp.ALU_FunSel = 5'b10000;
              endcase
              if (!src1[2]) begin
                dp.MuxDSel     = 1'b1;
                dp.ARF_OutCSel = src1[1:0];
              end else begin
                dp.RF_OutASel = {1'b0, src1[1:0]};
              end
              if (opcode != 4'h8) dp.RF_OutBSel = {1'b0, src2[1:0]};
              if (dst[2]) begin
                dp.MuxASel   = 2'b00;
                dp.RF_FunSel = 3'b010;
                dp.RF_RegSel = rf_onehot(dst[1:0]);
              end else begin
                dp.MuxBSel    = 2'b00;
                dp.ARF_FunSel = 2'b10;
                dp.ARF_RegSel = arf_onehot(dst[1:0]);
              end
              dp.ALU_WF = s_bit;
            end
          end
          4'h9: begin
            dp.ARF_OutDSel = 2'b10;
            dp.Mem_CS      = 1'b0;
            dp.DR_E        = 1'b1;
            dp.DR_FunSel   = 2'b01;
            last           = 1'b0;
          end
          4'hA: begin
            dp.RF_OutASel  = {1'b0, rsel};
            dp.ALU_FunSel  = 5'b10000;
            dp.MuxCSel     = 2'b00;
            dp.ARF_OutDSel = 2'b10;
            dp.Mem_CS      = 1'b0;
            dp.Mem_WR      = 1'b1;
          end
          4'hB: mode_d = HALT;
          default: Illegal = 1'b1;
        endcase
      end else if (sc_q == SC_W'(3) && opcode == 4'h9) begin
        dp.MuxASel   = 2'b10;
        dp.RF_FunSel = 3'b010;
        dp.RF_RegSel = rf_onehot(rsel);
        last         = 1'b1;
      end else begin
        // any other count is unreachable; recover by restarting the fetch
        last = 1'b1;
      end
      if (!hold) sc_d = (last || sc_q == '1) ? '0 : sc_q + SC_W'(1);
    end
  end

  assign T_State = sc_q;
  assign Halted  = (mode_q == HALT);

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - scoreboard bench for instruction_sequencer
module tb_instruction_sequencer;

  typedef struct packed {
    logic [2:0] oa, ob, rf_fun;
    logic [3:0] rf_reg, rf_scr;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [1:0] oc, od, arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh, ir_write, mem_wr, mem_cs;
    logic [1:0] ma, mb, mc;
    logic       md, dr_e;
    logic [1:0] dr_fun;
    logic [2:0] t;
    logic       halted, illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] t_state;
  logic       halted, illegal;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step = 1'b1;
`endif

  instruction_sequencer_if bus();

  instruction_sequencer #(.SC_W(3)) dut (
    .Clock   (clk),
    .Reset   (rst),
`ifdef SEQ_SINGLE_STEP_EN
    .Step    (step),
`endif
    .dp      (bus),
    .T_State (t_state),
    .Halted  (halted),
    .Illegal (illegal)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  ctl_t  exp_q[$];
  string tag_q[$];
  ctl_t  mon_e;
  string mon_tag;
  ctl_t  e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ctl_t observe();
    ctl_t o;
    o.oa = bus.RF_OutASel;   o.ob = bus.RF_OutBSel;   o.rf_fun = bus.RF_FunSel;
    o.rf_reg = bus.RF_RegSel; o.rf_scr = bus.RF_ScrSel;
    o.alu_fun = bus.ALU_FunSel; o.alu_wf = bus.ALU_WF;
    o.oc = bus.ARF_OutCSel;  o.od = bus.ARF_OutDSel;  o.arf_fun = bus.ARF_FunSel;
    o.arf_reg = bus.ARF_RegSel;
    o.ir_lh = bus.IR_LH; o.ir_write = bus.IR_Write; o.mem_wr = bus.Mem_WR; o.mem_cs = bus.Mem_CS;
    o.ma = bus.MuxASel; o.mb = bus.MuxBSel; o.mc = bus.MuxCSel; o.md = bus.MuxDSel;
    o.dr_e = bus.DR_E; o.dr_fun = bus.DR_FunSel;
    o.t = t_state; o.halted = halted; o.illegal = illegal;
    return o;
  endfunction

  function automatic ctl_t idle(input logic [2:0] t);
    ctl_t c = '0;
    c.mem_cs = 1'b1;
    c.t = t;
    return c;
  endfunction

  function automatic ctl_t fetch(input logic [2:0] t);
    ctl_t c = idle(t);
    c.mem_cs = 1'b0; c.ir_write = 1'b1; c.ir_lh = t[0];
    c.arf_fun = 2'b01; c.arf_reg = 3'b100;
    return c;
  endfunction

  function automatic ctl_t rst_vec(input logic [2:0] t, input logic h);
    ctl_t c = idle(t);
    c.rf_fun = 3'b011; c.rf_reg = 4'b1111; c.rf_scr = 4'b1111;
    c.arf_fun = 2'b11; c.arf_reg = 3'b111; c.halted = h;
    return c;
  endfunction

  function automatic ctl_t bra_vec();
    ctl_t c = idle(2);
    c.mb = 2'b11; c.arf_fun = 2'b10; c.arf_reg = 3'b100;
    return c;
  endfunction

  task automatic cyc(input logic r, input logic [15:0] ir, input logic [3:0] fl,
                     input ctl_t ex, input string tag, input bit chk = 1'b1);
    @(posedge clk);
    #1;
    rst = r;
    bus.IR_Value = ir;
    bus.Flags = fl;
    if (chk) begin
      exp_q.push_back(ex);
      tag_q.push_back(tag);
    end
  endtask

  task automatic fetch2(input logic [15:0] ir, input logic [3:0] fl, input string tag);
    cyc(1'b0, ir, fl, fetch(0), {tag, "_t0"});
    cyc(1'b0, ir, fl, fetch(1), {tag, "_t1"});
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      check(mon_tag, 64'(observe()), 64'(mon_e));
    end
  end

  initial begin
    rst = 1'b1;
    bus.IR_Value = 16'h0000;
    bus.Flags = 4'h0;

    cyc(1'b1, 16'h0000, 4'h0, idle(0), "rst0", 1'b0);
    cyc(1'b1, 16'h0000, 4'h0, rst_vec(0, 1'b0), "reset");

    fetch2(16'h2105, 4'h0, "movl");
    e = idle(2); e.ma = 2'b11; e.rf_fun = 3'b010; e.rf_reg = 4'b0100;
    cyc(1'b0, 16'h2105, 4'h0, e, "movl_t2");

    fetch2(16'h3DB8, 4'h0, "add_rr");
    e = idle(2); e.alu_fun = 5'b10100; e.alu_wf = 1'b1; e.oa = 3'b001; e.ob = 3'b010;
    e.rf_fun = 3'b010; e.rf_reg = 4'b0100;
    cyc(1'b0, 16'h3DB8, 4'h0, e, "add_rr_t2");

    fetch2(16'h3D38, 4'h0, "add_pc");
    e = idle(2); e.alu_fun = 5'b10100; e.alu_wf = 1'b1; e.md = 1'b1; e.oc = 2'b01; e.ob = 3'b010;
    e.rf_fun = 3'b010; e.rf_reg = 4'b0100;
    cyc(1'b0, 16'h3D38, 4'h0, e, "add_pc_t2");

    fetch2(16'h427C, 4'h0, "sub_ar");
    e = idle(2); e.alu_fun = 5'b10110; e.md = 1'b1; e.oc = 2'b11; e.ob = 3'b011;
    e.arf_fun = 2'b10; e.arf_reg = 3'b010;
    cyc(1'b0, 16'h427C, 4'h0, e, "sub_ar_t2");

    fetch2(16'h55A0, 4'h0, "and_bad");
    e = idle(2); e.illegal = 1'b1;
    cyc(1'b0, 16'h55A0, 4'h0, e, "and_bad_t2");

    fetch2(16'h84E0, 4'h0, "mov");
    e = idle(2); e.alu_fun = 5'b10000; e.oa = 3'b011; e.rf_fun = 3'b010; e.rf_reg = 4'b1000;
    cyc(1'b0, 16'h84E0, 4'h0, e, "mov_t2");

    fetch2(16'h0040, 4'h0, "bra");
    cyc(1'b0, 16'h0040, 4'h0, bra_vec(), "bra_t2");

    fetch2(16'h1010, 4'b1000, "bne_z1");
    cyc(1'b0, 16'h1010, 4'b1000, idle(2), "bne_z1_t2");

    fetch2(16'h1010, 4'b0111, "bne_z0");
    cyc(1'b0, 16'h1010, 4'b0111, bra_vec(), "bne_z0_t2");

    fetch2(16'hA200, 4'h0, "st");
    e = idle(2); e.oa = 3'b010; e.alu_fun = 5'b10000; e.od = 2'b10; e.mem_cs = 1'b0; e.mem_wr = 1'b1;
    cyc(1'b0, 16'hA200, 4'h0, e, "st_t2");

    fetch2(16'h9000, 4'h0, "ld");
    e = idle(2); e.od = 2'b10; e.mem_cs = 1'b0; e.dr_e = 1'b1; e.dr_fun = 2'b01;
    cyc(1'b0, 16'h9000, 4'h0, e, "ld_t2");
    e = idle(3); e.ma = 2'b10; e.rf_fun = 3'b010; e.rf_reg = 4'b1000;
    cyc(1'b0, 16'h9000, 4'h0, e, "ld_t3");

    fetch2(16'h9300, 4'h0, "ld_ab");
    e = idle(2); e.od = 2'b10; e.mem_cs = 1'b0; e.dr_e = 1'b1; e.dr_fun = 2'b01;
    cyc(1'b0, 16'h9300, 4'h0, e, "ld_ab_t2");
    cyc(1'b1, 16'h9300, 4'h0, rst_vec(3, 1'b0), "ld_abort");

    fetch2(16'hE000, 4'h0, "ill");
    e = idle(2); e.illegal = 1'b1;
    cyc(1'b0, 16'hE000, 4'h0, e, "ill_t2");

    fetch2(16'hB000, 4'h0, "hlt");
    cyc(1'b0, 16'hB000, 4'h0, idle(2), "hlt_t2");
    e = idle(0); e.halted = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1'b0, 16'hB000, 4'h0, e, $sformatf("halted_%0d", i));
    cyc(1'b1, 16'hB000, 4'h0, rst_vec(0, 1'b1), "hlt_reset");

    fetch2(16'h2307, 4'h0, "movl4");
    e = idle(2); e.ma = 2'b11; e.rf_fun = 3'b010; e.rf_reg = 4'b0001;
    cyc(1'b0, 16'h2307, 4'h0, e, "movl4_t2");
    cyc(1'b0, 16'h2307, 4'h0, fetch(0), "after_t0");

    repeat (3) @(posedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
